// File: rtl/iq_demod_pkg.sv
// Shared constants and sample type for the IQ demodulator front end.
package iq_demod_pkg;

    localparam int IQ_SAMPLE_W  = 5;
    localparam int IQ_TAP_DEPTH = 10;
    localparam int IQ_NCH       = 2;
    localparam int IQ_DECIM     = 8;

    typedef logic [IQ_SAMPLE_W-1:0] iq_sample_t;

    // Width of the phase select / decimation counter; never narrower than one bit.
    function automatic int phase_w(input int decim);
        return (decim > 1) ? $clog2(decim) : 1;
    endfunction

endpackage

// File: rtl/iq_tap_chan.sv
// Single-channel tap shift chain; tap 0 holds the newest kept sample.
module iq_tap_chan
    import iq_demod_pkg::*;
#(
    parameter int P_WIDTH = IQ_SAMPLE_W,
    parameter int P_DEPTH = IQ_TAP_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       shift_en,
    input  logic [P_WIDTH-1:0]         din,
    output logic [P_DEPTH*P_WIDTH-1:0] taps
);

    logic [P_DEPTH-1:0][P_WIDTH-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            chain <= '0;
        else if (clear)
            chain <= '0;
        else if (shift_en)
            chain <= {chain[P_DEPTH-2:0], din};
    end

    assign taps = chain;

endmodule

// File: rtl/iq_tap_line.sv
// Multi-channel decimating tap line: phase-selected decimation, fill tracking and window strobe.
module iq_tap_line
    import iq_demod_pkg::*;
#(
    parameter  int P_WIDTH = IQ_SAMPLE_W,
    parameter  int P_DEPTH = IQ_TAP_DEPTH,
    parameter  int P_NCH   = IQ_NCH,
    parameter  int P_DECIM = IQ_DECIM,
    localparam int PS_W    = phase_w(P_DECIM),
    localparam int FILL_W  = $clog2(P_DEPTH + 1)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush,
    input  logic [PS_W-1:0]                    phase_sel,
    input  logic                               in_valid,
    input  logic [P_NCH*P_WIDTH-1:0]           in_data,
    output logic [P_NCH*P_DEPTH*P_WIDTH-1:0]   taps,
    output logic [FILL_W-1:0]                  fill,
    output logic                               full,
    output logic                               win_strobe
);

    logic [PS_W-1:0] dec_cnt;
    logic            shift;

    // A phase_sel outside 0..P_DECIM-1 never matches, so nothing is kept.
    assign shift = in_valid && !flush && ((P_DECIM == 1) || (dec_cnt == phase_sel));
    assign full  = (fill == FILL_W'(P_DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_cnt    <= '0;
            fill       <= '0;
            win_strobe <= 1'b0;
        end else if (flush) begin
            dec_cnt    <= '0;
            fill       <= '0;
            win_strobe <= 1'b0;
        end else begin
            // Post-shift fill reaches P_DEPTH when the pre-shift fill is at least P_DEPTH-1.
            win_strobe <= shift && (fill >= FILL_W'(P_DEPTH - 1));
            if (in_valid)
                dec_cnt <= (dec_cnt == PS_W'(P_DECIM - 1)) ? '0 : dec_cnt + 1'b1;
            if (shift && !full)
                fill <= fill + 1'b1;
        end
    end

    for (genvar c = 0; c < P_NCH; c++) begin : g_chan
        iq_tap_chan #(
            .P_WIDTH (P_WIDTH),
            .P_DEPTH (P_DEPTH)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .clear    (flush),
            .shift_en (shift),
            .din      (in_data[c*P_WIDTH +: P_WIDTH]),
            .taps     (taps[c*P_DEPTH*P_WIDTH +: P_DEPTH*P_WIDTH])
        );
    end

endmodule

// File: tb/tb_iq_tap_line.sv
// Scoreboard bench: default I/Q build, a decimate-by-1 three-channel build, and an out-of-range phase build.
module tb_iq_tap_line;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, in_valid;
    logic [2:0]  ph_a, ph_c;
    logic [9:0]  in_data;
    logic [99:0] taps_a, taps_c;
    logic [3:0]  fill_a, fill_c;
    logic        full_a, full_c, win_a, win_c;

    logic        ph_b, valid_b;
    logic [14:0] data_b;
    logic [59:0] taps_b;
    logic [2:0]  fill_b;
    logic        full_b, win_b;

    iq_tap_line dut_a (
        .clk(clk), .reset(reset), .flush(flush), .phase_sel(ph_a), .in_valid(in_valid),
        .in_data(in_data), .taps(taps_a), .fill(fill_a), .full(full_a), .win_strobe(win_a));

    iq_tap_line #(.P_WIDTH(5), .P_DEPTH(4), .P_NCH(3), .P_DECIM(1)) dut_b (
        .clk(clk), .reset(reset), .flush(1'b0), .phase_sel(ph_b), .in_valid(valid_b),
        .in_data(data_b), .taps(taps_b), .fill(fill_b), .full(full_b), .win_strobe(win_b));

    iq_tap_line #(.P_DECIM(6)) dut_c (
        .clk(clk), .reset(reset), .flush(flush), .phase_sel(ph_c), .in_valid(in_valid),
        .in_data(in_data), .taps(taps_c), .fill(fill_c), .full(full_c), .win_strobe(win_c));

    int n_tests = 0;
    int n_fail  = 0;
    int strobes_a = 0;
    int strobes_c = 0;
    logic [99:0] exp_q[$];

    // reference model of dut_a
    int m_cnt, m_fill;
    int hi[10], hq[10];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [99:0] pack_a(input int i[10], input int q[10]);
        logic [99:0] v;
        for (int k = 0; k < 10; k++) begin
            v[k*5 +: 5]      = 5'(i[k]);
            v[(10+k)*5 +: 5] = 5'(q[k]);
        end
        return v;
    endfunction

    task automatic model_clear();
        m_cnt = 0; m_fill = 0;
        for (int k = 0; k < 10; k++) begin hi[k] = 0; hq[k] = 0; end
    endtask

    task automatic step(input logic v, input logic fl, input int di, input int dq);
        in_valid = v; flush = fl; in_data = {5'(dq), 5'(di)};
        @(posedge clk);
        if (fl) model_clear();
        else if (v) begin
            if (m_cnt == int'(ph_a)) begin
                for (int k = 9; k > 0; k--) begin hi[k] = hi[k-1]; hq[k] = hq[k-1]; end
                hi[0] = di & 31; hq[0] = dq & 31;
                if (m_fill < 10) m_fill++;
                if (m_fill == 10) exp_q.push_back(pack_a(hi, hq));
            end
            m_cnt = (m_cnt == 7) ? 0 : m_cnt + 1;
        end
        #1;
        in_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic step_b(input logic v, input int s);
        valid_b = v;
        data_b  = {5'(s + 20), 5'(s + 10), 5'(s)};
        @(posedge clk);
        #1;
        valid_b = 1'b0;
    endtask

    always @(negedge clk) begin
        if (win_c) strobes_c++;
        if (win_a) begin
            strobes_a++;
            if (exp_q.size() == 0) chk("strobe_unexpected", 128'(win_a), 128'(0));
            else chk("window_taps", 128'(taps_a), 128'(exp_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ei[10], eq[10];
        int base;
        logic [59:0] eb;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        ph_a = 3'd0; ph_c = 3'd7; ph_b = 1'b1; valid_b = 1'b0; data_b = '0;
        model_clear();
        #3;
        chk("reset_taps", 128'(taps_a), 128'(0));
        chk("reset_fill", 128'(fill_a), 128'(0));
        chk("reset_full", 128'(full_a), 128'(0));
        chk("reset_strobe", 128'(win_a), 128'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // decimate by 8 at phase 0: I=n, Q=31-n
        for (int n = 0; n < 80; n++) step(1'b1, 1'b0, n, 31 - n);
        ei = '{8, 0, 24, 16, 8, 0, 24, 16, 8, 0};
        eq = '{23, 31, 7, 15, 23, 31, 7, 15, 23, 31};
        chk("d8_fill", 128'(fill_a), 128'(10));
        chk("d8_full", 128'(full_a), 128'(1));
        chk("d8_taps", 128'(taps_a), 128'(pack_a(ei, eq)));
        chk("d8_strobe_count", 128'(strobes_a), 128'(1));

        // misalign dec_cnt, then flush with a valid sample
        for (int n = 80; n < 83; n++) step(1'b1, 1'b0, n, 31 - n);
        step(1'b1, 1'b1, 17, 17);
        chk("flush_taps", 128'(taps_a), 128'(0));
        chk("flush_fill", 128'(fill_a), 128'(0));
        chk("flush_strobe", 128'(win_a), 128'(0));
        base = strobes_a;
        step(1'b1, 1'b0, 5, 6);
        chk("flush_realign_fill", 128'(fill_a), 128'(1));
        chk("flush_realign_tap0", 128'(taps_a[4:0]), 128'(5));
        for (int v = 1; v < 72; v++) step(1'b1, 1'b0, v, v);
        chk("refill_9_fill", 128'(fill_a), 128'(9));
        chk("refill_9_no_strobe", 128'(strobes_a), 128'(base));
        for (int v = 72; v < 80; v++) step(1'b1, 1'b0, v, v);
        @(negedge clk); #1;
        chk("refill_10_fill", 128'(fill_a), 128'(10));
        chk("refill_10_strobe", 128'(strobes_a), 128'(base + 1));

        // phase 3, valid every other cycle
        step(1'b0, 1'b1, 0, 0);
        ph_a = 3'd3; ph_c = 3'd6;
        for (int v = 0; v < 20; v++) begin
            step(1'b1, 1'b0, v, v + 1);
            step(1'b0, 1'b0, 31, 31);
        end
        ei = '{19, 11, 3, 0, 0, 0, 0, 0, 0, 0};
        eq = '{20, 12, 4, 0, 0, 0, 0, 0, 0, 0};
        chk("ph3_fill", 128'(fill_a), 128'(3));
        chk("ph3_taps", 128'(taps_a), 128'(pack_a(ei, eq)));

        // dec_cnt now 4: phase 0 keeps indices 4,12,..,76 -> full with strobe on last step
        ph_a = 3'd0;
        for (int v = 0; v < 77; v++) step(1'b1, 1'b0, v, v);
        chk("prereset_full", 128'(full_a), 128'(1));
        chk("prereset_strobe", 128'(win_a), 128'(1));
        #1 reset = 1'b1;
        #1;
        chk("async_reset_taps", 128'(taps_a), 128'(0));
        chk("async_reset_fill", 128'(fill_a), 128'(0));
        chk("async_reset_full", 128'(full_a), 128'(0));
        chk("async_reset_strobe", 128'(win_a), 128'(0));
        model_clear();
        exp_q.delete();
        #1 reset = 1'b0;
        step(1'b1, 1'b0, 9, 9);
        chk("postreset_fill", 128'(fill_a), 128'(1));

        // decimate-by-1, 3-channel, depth-4 build
        for (int s = 1; s <= 6; s++) begin
            step_b(1'b1, s);
            chk($sformatf("b_strobe_%0d", s), 128'(win_b), 128'(s >= 4));
            chk($sformatf("b_fill_%0d", s), 128'(fill_b), 128'(s < 4 ? s : 4));
        end
        chk("b_full", 128'(full_b), 128'(1));
        eb = '0;
        for (int c = 0; c < 3; c++)
            for (int k = 0; k < 4; k++)
                eb[(c*4 + k)*5 +: 5] = 5'(6 - k + 10*c);
        chk("b_taps", 128'(taps_b), 128'(eb));
        step_b(1'b0, 0);
        chk("b_idle_strobe", 128'(win_b), 128'(0));

        // out-of-range phase build saw hundreds of valid samples
        chk("oor_fill", 128'(fill_c), 128'(0));
        chk("oor_strobes", 128'(strobes_c), 128'(0));
        chk("pending_windows", 128'(exp_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
